// File: rtl/operand_fetch_pkg.sv
// Shared widths, operand-bundle type and register-address decode for the
// operand fetch stage and its scoreboard.
package operand_fetch_pkg;

  localparam int unsigned DATA_WIDTH = 16;
  localparam int unsigned ADDR_WIDTH = 3;
  localparam int unsigned NUM_REGS   = 1 << ADDR_WIDTH;

  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [NUM_REGS-1:0]   reg_mask_t;

  typedef struct packed {
    data_t op1;
    data_t op2;
    addr_t dest;
    logic  wr;
  } operand_bundle_t;

  // Same one-hot decode the register file uses for its write demux.
  function automatic reg_mask_t addr_to_mask(input addr_t add);
    reg_mask_t mask;
    mask      = '0;
    mask[add] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// Decode/register-file/write-back/execute signals seen by operand_fetch.
// master is the surrounding pipeline, slave is operand_fetch itself.
interface operand_fetch_if;
  import operand_fetch_pkg::*;

  logic  in_valid;
  logic  in_ready;
  addr_t in_src1;
  addr_t in_src2;
  logic  in_use1;
  logic  in_use2;
  addr_t in_dest;
  logic  in_wr;

  addr_t readAdd1;
  addr_t readAdd2;
  data_t rf_out1;
  data_t rf_out2;

  logic  wb_write;
  addr_t wb_add;
  data_t wb_data;

  logic  out_valid;
  logic  out_ready;
  data_t out_op1;
  data_t out_op2;
  addr_t out_dest;
  logic  out_wr;

  modport master (
    output in_valid, in_src1, in_src2, in_use1, in_use2, in_dest, in_wr,
    output rf_out1, rf_out2, wb_write, wb_add, wb_data, out_ready,
    input  in_ready, readAdd1, readAdd2,
    input  out_valid, out_op1, out_op2, out_dest, out_wr
  );

  modport slave (
    input  in_valid, in_src1, in_src2, in_use1, in_use2, in_dest, in_wr,
    input  rf_out1, rf_out2, wb_write, wb_add, wb_data, out_ready,
    output in_ready, readAdd1, readAdd2,
    output out_valid, out_op1, out_op2, out_dest, out_wr
  );

endinterface

// File: rtl/operand_fetch_reg_scoreboard.sv
// Pending-write scoreboard: one bit per register with an in-flight writer.
// busy already reflects a write-back retiring in the current cycle.
module reg_scoreboard #(
  parameter int unsigned NUM_REGS   = operand_fetch_pkg::NUM_REGS,
  parameter int unsigned ADDR_WIDTH = operand_fetch_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  set_en,
  input  logic [ADDR_WIDTH-1:0] set_add,
  input  logic                  clr_en,
  input  logic [ADDR_WIDTH-1:0] clr_add,
  output logic [NUM_REGS-1:0]   busy
);

  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en) set_mask = operand_fetch_pkg::addr_to_mask(set_add);
    if (clr_en) clr_mask = operand_fetch_pkg::addr_to_mask(clr_add);
  end

  assign busy = pending & ~clr_mask;

  // Set applied after clear: a newly issued writer outranks the retiring one.
  always_ff @(posedge clk) begin
    if (reset) pending <= '0;
    else       pending <= (pending & ~clr_mask) | set_mask;
  end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: register-file read with write-back bypass, RAW/WAW hazard
// stall via scoreboard, registered operand bundle and saturating stall count.
module operand_fetch #(
  parameter int unsigned DATA_WIDTH      = operand_fetch_pkg::DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH      = operand_fetch_pkg::ADDR_WIDTH,
  parameter int unsigned NUM_REGS        = operand_fetch_pkg::NUM_REGS,
  parameter int unsigned STALL_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  operand_fetch_if.slave             bus,
  output logic [STALL_CNT_WIDTH-1:0] stall_count
);

  logic [NUM_REGS-1:0]   busy;
  logic                  hazard;
  logic                  accept;
  logic [DATA_WIDTH-1:0] op1_sel;
  logic [DATA_WIDTH-1:0] op2_sel;
  logic                  out_valid_q;

  operand_fetch_pkg::operand_bundle_t bundle_q;

  assign bus.readAdd1 = bus.in_src1;
  assign bus.readAdd2 = bus.in_src2;

  assign hazard = (bus.in_use1 && busy[bus.in_src1]) ||
                  (bus.in_use2 && busy[bus.in_src2]) ||
                  (bus.in_wr   && busy[bus.in_dest]);

  assign bus.in_ready = !reset && (!out_valid_q || bus.out_ready) && !hazard;
  assign accept       = bus.in_valid && bus.in_ready;

  // The file only updates at the edge, so a same-cycle write-back is forwarded.
  assign op1_sel = (bus.wb_write && bus.wb_add == bus.in_src1) ? bus.wb_data : bus.rf_out1;
  assign op2_sel = (bus.wb_write && bus.wb_add == bus.in_src2) ? bus.wb_data : bus.rf_out2;

  reg_scoreboard #(
    .NUM_REGS  (NUM_REGS),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_scoreboard (
    .clk    (clk),
    .reset  (reset),
    .set_en (accept && bus.in_wr),
    .set_add(bus.in_dest),
    .clr_en (bus.wb_write),
    .clr_add(bus.wb_add),
    .busy   (busy)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      bundle_q    <= '0;
    end else if (accept) begin
      out_valid_q   <= 1'b1;
      bundle_q.op1  <= op1_sel;
      bundle_q.op2  <= op2_sel;
      bundle_q.dest <= bus.in_dest;
      bundle_q.wr   <= bus.in_wr;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                                          stall_count <= '0;
    else if (bus.in_valid && hazard && stall_count != '1) stall_count <= stall_count + 1'b1;
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_op1   = bundle_q.op1;
  assign bus.out_op2   = bundle_q.op2;
  assign bus.out_dest  = bundle_q.dest;
  assign bus.out_wr    = bundle_q.wr;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed scenarios plus random traffic, checked
// against a cycle-level reference model of the handshake/scoreboard rules.
module tb_operand_fetch;

  localparam int unsigned SCW     = 4;
  localparam int unsigned SAT_MAX = (1 << SCW) - 1;

  logic           clk = 1'b0;
  logic           reset;
  logic [SCW-1:0] stall_count;
  logic [15:0]    regs [8];

  int n_compared   = 0;
  int n_mismatched = 0;

  // reference model state
  logic [7:0]  m_pend;
  logic        m_valid;
  logic [15:0] m_op1, m_op2;
  logic [2:0]  m_dest;
  logic        m_wr;
  int          m_stall;

  operand_fetch_if bus ();

  operand_fetch #(.STALL_CNT_WIDTH(SCW)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] preload(input int i);
    case (i)
      2:       return 16'h1234;
      5:       return 16'hBEEF;
      default: return 16'(i * 16'h1111 + 16'h0101);
    endcase
  endfunction

  // register file: reset preloads, write-back updates at the edge
  assign bus.rf_out1 = regs[bus.readAdd1];
  assign bus.rf_out2 = regs[bus.readAdd2];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) regs[i] <= preload(i);
    end else if (bus.wb_write) begin
      regs[bus.wb_add] <= bus.wb_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic issue(input bit v, input int s1, input bit u1, input int s2, input bit u2,
                       input int d, input bit w);
    bus.in_valid = v;
    bus.in_src1  = 3'(s1);
    bus.in_use1  = u1;
    bus.in_src2  = 3'(s2);
    bus.in_use2  = u2;
    bus.in_dest  = 3'(d);
    bus.in_wr    = w;
  endtask

  task automatic wb(input bit e, input int a, input logic [15:0] dat);
    bus.wb_write = e;
    bus.wb_add   = 3'(a);
    bus.wb_data  = dat;
  endtask

  // Check current outputs against the model, advance the model, cross one edge.
  task automatic step();
    logic       haz, rdy, acc;
    logic [7:0] busyv;
    int         s1, s2, d;
    #1;
    s1 = int'(bus.in_src1);
    s2 = int'(bus.in_src2);
    d  = int'(bus.in_dest);
    for (int r = 0; r < 8; r++)
      busyv[r] = m_pend[r] && !(bus.wb_write && int'(bus.wb_add) == r);
    haz = (bus.in_use1 && busyv[s1]) || (bus.in_use2 && busyv[s2]) || (bus.in_wr && busyv[d]);
    rdy = !reset && (!m_valid || bus.out_ready) && !haz;

    check("in_ready",    32'(bus.in_ready),  32'(rdy));
    check("readAdd1",    32'(bus.readAdd1),  32'(s1));
    check("readAdd2",    32'(bus.readAdd2),  32'(s2));
    check("out_valid",   32'(bus.out_valid), 32'(m_valid));
    check("out_op1",     32'(bus.out_op1),   32'(m_op1));
    check("out_op2",     32'(bus.out_op2),   32'(m_op2));
    check("out_dest",    32'(bus.out_dest),  32'(m_dest));
    check("out_wr",      32'(bus.out_wr),    32'(m_wr));
    check("stall_count", 32'(stall_count),   32'(m_stall));

    acc = bus.in_valid && rdy;
    if (reset) begin
      m_valid = 0; m_op1 = '0; m_op2 = '0; m_dest = '0; m_wr = 0;
      m_pend  = '0; m_stall = 0;
    end else begin
      if (acc) begin
        m_op1   = (bus.wb_write && bus.wb_add == bus.in_src1) ? bus.wb_data : regs[s1];
        m_op2   = (bus.wb_write && bus.wb_add == bus.in_src2) ? bus.wb_data : regs[s2];
        m_dest  = bus.in_dest;
        m_wr    = bus.in_wr;
        m_valid = 1;
      end else if (bus.out_ready) begin
        m_valid = 0;
      end
      if (bus.wb_write)      m_pend[bus.wb_add] = 1'b0;
      if (acc && bus.in_wr)  m_pend[d]          = 1'b1;
      if (bus.in_valid && haz && m_stall < int'(SAT_MAX)) m_stall++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int saved_stall;
    reset = 1'b1;
    issue(0, 0, 0, 0, 0, 0, 0);
    wb(0, 0, '0);
    bus.out_ready = 1'b1;
    m_pend = '0; m_valid = 0; m_op1 = '0; m_op2 = '0; m_dest = '0; m_wr = 0; m_stall = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    step();
    reset = 1'b0;

    // basic fetch of R2/R5
    issue(1, 2, 1, 5, 1, 0, 0);
    step();
    issue(0, 0, 0, 0, 0, 0, 0);
    check("t1_valid", 32'(bus.out_valid), 32'd1);
    check("t1_op1",   32'(bus.out_op1),   32'h1234);
    check("t1_op2",   32'(bus.out_op2),   32'hBEEF);
    check("t1_stall", 32'(stall_count),   32'd0);
    step();

    // RAW stall on R3, released by same-cycle write-back with bypass
    issue(1, 0, 0, 0, 0, 3, 1);
    step();
    issue(1, 3, 1, 0, 0, 0, 0);
    #1 check("t2_stall_rdy", 32'(bus.in_ready), 32'd0);
    step();
    step();
    check("t2_stall_cnt", 32'(stall_count), 32'd2);
    wb(1, 3, 16'h00A5);
    #1 check("t2_wb_rdy", 32'(bus.in_ready), 32'd1);
    step();
    wb(0, 0, '0);
    check("t2_bypass", 32'(bus.out_op1), 32'h00A5);
    issue(1, 3, 1, 0, 0, 0, 0);
    #1 check("t2_r3_free", 32'(bus.in_ready), 32'd1);
    step();

    // WAW with same-cycle set/clear on R4: set wins
    issue(1, 0, 0, 0, 0, 4, 1);
    step();
    issue(1, 0, 0, 0, 0, 4, 1);
    wb(1, 4, 16'h4444);
    #1 check("t3_waw_rdy", 32'(bus.in_ready), 32'd1);
    step();
    wb(0, 0, '0);
    issue(1, 4, 1, 0, 0, 0, 0);
    #1 check("t3_r4_busy", 32'(bus.in_ready), 32'd0);
    step();
    issue(0, 0, 0, 0, 0, 0, 0);
    wb(1, 4, 16'h4545);
    step();
    wb(0, 0, '0);

    // backpressure holds the bundle and is not a stall
    issue(1, 2, 1, 5, 1, 0, 0);
    step();
    bus.out_ready = 1'b0;
    issue(1, 0, 0, 1, 0, 0, 0);
    saved_stall = m_stall;
    for (int i = 0; i < 5; i++) begin
      #1 check("t4_bp_rdy", 32'(bus.in_ready), 32'd0);
      step();
      check("t4_bp_op1",   32'(bus.out_op1), 32'h1234);
      check("t4_bp_op2",   32'(bus.out_op2), 32'hBEEF);
      check("t4_bp_stall", 32'(stall_count), 32'(saved_stall));
    end
    bus.out_ready = 1'b1;
    #1 check("t4_release_rdy", 32'(bus.in_ready), 32'd1);
    step();

    // reset mid-flight drops bundle and scoreboard
    issue(1, 0, 0, 0, 0, 1, 1);
    step();
    issue(1, 0, 0, 0, 0, 6, 1);
    step();
    check("t5_valid_before", 32'(bus.out_valid), 32'd1);
    reset = 1'b1;
    wb(1, 1, 16'hDEAD);
    step();
    reset = 1'b0;
    wb(0, 0, '0);
    check("t5_valid_after", 32'(bus.out_valid), 32'd0);
    check("t5_stall_after", 32'(stall_count),   32'd0);
    issue(1, 1, 1, 6, 1, 0, 0);
    #1 check("t5_r1_free", 32'(bus.in_ready), 32'd1);
    step();

    // stall counter saturation
    issue(1, 0, 0, 0, 0, 7, 1);
    step();
    issue(1, 7, 1, 0, 0, 0, 0);
    for (int i = 0; i < (1 << SCW) + 3; i++) step();
    check("t6_saturated", 32'(stall_count), 32'(SAT_MAX));
    issue(0, 0, 0, 0, 0, 0, 0);
    wb(1, 7, 16'h7777);
    step();
    wb(0, 0, '0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 49) == 0);
      issue($urandom_range(0, 9) < 7,
            int'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
            int'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
            int'($urandom_range(0, 7)), $urandom_range(0, 2) != 0);
      wb($urandom_range(0, 9) < 4, int'($urandom_range(0, 7)), 16'($urandom));
      bus.out_ready = ($urandom_range(0, 9) < 7);
      step();
    end

    reset = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
